// File: rtl/window_gen3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one packed window per interior pixel with one cycle of latency.
module window_gen3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     s_pixel_data,
  input  logic                      s_pixel_valid,
  input  logic                      s_pixel_sof,
  output logic [9*DATA_WIDTH-1:0]   m_matrix_data,
  output logic                      m_matrix_valid,
  output logic                      m_line_last,
  output logic                      m_frame_last
);

  // Handshake: a pixel is consumed in every cycle s_pixel_valid=1 (no ready);
  // m_matrix_valid is a one-cycle qualifier for m_matrix_data/m_line_last/m_frame_last.

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          accept;
  logic          emit;
  logic          at_line_end;

  logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1_rd;
  logic [DATA_WIDTH-1:0] line2_rd;

  logic [DATA_WIDTH-1:0] win [9];

  // Sof forces the current pixel to (0,0) regardless of the running counters.
  always_comb begin
    cur_x       = s_pixel_sof ? '0 : x_cnt;
    cur_y       = s_pixel_sof ? '0 : y_cnt;
    accept      = s_pixel_valid && !reset;
    at_line_end = (cur_x == X_LAST);
    next_x      = at_line_end ? '0 : cur_x + XW'(1);
    next_y      = cur_y;
    if (at_line_end) begin
      next_y = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
    end
    emit     = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    line1_rd = line1[cur_x];
    line2_rd = line2[cur_x];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (s_pixel_valid) begin
      x_cnt <= next_x;
      y_cnt <= next_y;
    end
  end

  // Line buffers are never cleared; the y>=2 gate keeps stale lines out of the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      line2[cur_x] <= line1_rd;
      line1[cur_x] <= s_pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (s_pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3+0] <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= line2_rd;
      win[5] <= line1_rd;
      win[8] <= s_pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_matrix_valid <= 1'b0;
      m_line_last    <= 1'b0;
      m_frame_last   <= 1'b0;
    end else begin
      m_matrix_valid <= s_pixel_valid && emit;
      m_line_last    <= s_pixel_valid && emit && at_line_end;
      m_frame_last   <= s_pixel_valid && emit && at_line_end && (cur_y == Y_LAST);
    end
  end

  always_comb begin
    m_matrix_data = '0;
    for (int i = 0; i < 9; i++) begin
      m_matrix_data[i*DATA_WIDTH +: DATA_WIDTH] = win[i];
    end
  end

endmodule

// File: tb/tb_window_gen3x3.sv
// Bench for window_gen3x3 on a 4x4 image: directed frames with literal expectations
// plus randomized valid/sof/reset traffic checked every cycle against an image model.
module tb_window_gen3x3;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   s_pixel_data;
  logic            s_pixel_valid;
  logic            s_pixel_sof;
  logic [9*DW-1:0] m_matrix_data;
  logic            m_matrix_valid;
  logic            m_line_last;
  logic            m_frame_last;

  window_gen3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_pixel_data   (s_pixel_data),
    .s_pixel_valid  (s_pixel_valid),
    .s_pixel_sof    (s_pixel_sof),
    .m_matrix_data  (m_matrix_data),
    .m_matrix_valid (m_matrix_valid),
    .m_line_last    (m_line_last),
    .m_frame_last   (m_frame_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the image as a 2D array addressed by frame coordinates.
  logic [DW-1:0] mem [H][W];
  int            mx = 0;
  int            my = 0;
  logic          armed = 1'b0;
  logic          exp_v = 1'b0, exp_ll = 1'b0, exp_fl = 1'b0, exp_rst = 1'b0;
  logic [71:0]   exp_d = '0;

  always @(posedge clk) begin
    int cx, cy;
    armed = 1'b1;
    exp_v = 1'b0; exp_ll = 1'b0; exp_fl = 1'b0; exp_rst = 1'b0;
    if (reset) begin
      mx = 0; my = 0; exp_d = '0; exp_rst = 1'b1;
    end else if (s_pixel_valid) begin
      cx = s_pixel_sof ? 0 : mx;
      cy = s_pixel_sof ? 0 : my;
      mem[cy][cx] = s_pixel_data;
      if (cx >= 2 && cy >= 2) begin
        exp_v = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_d[(r*3+c)*DW +: DW] = mem[cy-2+r][cx-2+c];
        exp_ll = (cx == W-1);
        exp_fl = exp_ll && (cy == H-1);
      end
      mx = (cx + 1) % W;
      my = (cx == W-1) ? (cy + 1) % H : cy;
    end
  end

  // Per-cycle compare plus a log of emitted windows for the directed checks.
  logic [71:0] win_q[$];
  logic        ll_q[$];
  logic        fl_q[$];
  logic        prev_v = 1'b0;
  int          consec = 0;

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", m_matrix_valid, exp_v);
      chk("line_last", m_line_last, exp_ll);
      chk("frame_last", m_frame_last, exp_fl);
      if (exp_v || exp_rst) chk("data", m_matrix_data, exp_d);
    end
    if (m_matrix_valid) begin
      win_q.push_back(m_matrix_data);
      ll_q.push_back(m_line_last);
      fl_q.push_back(m_frame_last);
      if (prev_v) consec++;
    end
    prev_v = m_matrix_valid;
  end

  task automatic drive(input logic rst, input logic v, input logic sof, input logic [DW-1:0] d);
    @(negedge clk);
    reset = rst; s_pixel_valid = v; s_pixel_sof = sof; s_pixel_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_log();
    win_q.delete(); ll_q.delete(); fl_q.delete(); consec = 0;
  endtask

  // Frame of y*16+x; npix limits how many pixels are sent, gap inserts idle cycles.
  task automatic send_frame(input logic sof, input logic gap, input int npix);
    for (int k = 0; k < npix; k++) begin
      drive(1'b0, 1'b1, sof && (k == 0), DW'(((k / W) * 16) + (k % W)));
      if (gap) drive(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic check_std_frame(input string tag, input int base);
    logic [7:0] cen [4];
    logic [3:0] ll_bits, fl_bits;
    cen[0] = 8'h11; cen[1] = 8'h12; cen[2] = 8'h21; cen[3] = 8'h22;
    ll_bits = '0; fl_bits = '0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_centre"}, win_q[base+i][4*DW +: DW], cen[i]);
      ll_bits[i] = ll_q[base+i];
      fl_bits[i] = fl_q[base+i];
    end
    chk({tag, "_first_e0"}, win_q[base][0 +: DW], 8'h00);
    chk({tag, "_first_e8"}, win_q[base][8*DW +: DW], 8'h22);
    chk({tag, "_line_last_pattern"}, ll_bits, 4'b1010);
    chk({tag, "_frame_last_pattern"}, fl_bits, 4'b1000);
  endtask

  initial begin
    reset = 1'b1; s_pixel_valid = 1'b0; s_pixel_sof = 1'b0; s_pixel_data = '0;
    idle(0);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    idle(2);

    // Continuous frame with sof.
    clear_log();
    send_frame(1'b1, 1'b0, W*H);
    idle(3);
    chk("t1_count", win_q.size(), 4);
    if (win_q.size() == 4) check_std_frame("t1", 0);

    // Valid toggling every cycle.
    clear_log();
    send_frame(1'b1, 1'b1, W*H);
    idle(3);
    chk("t2_count", win_q.size(), 4);
    chk("t2_no_consecutive", consec, 0);
    if (win_q.size() == 4) check_std_frame("t2", 0);

    // Two back-to-back frames, no sof on the second.
    clear_log();
    send_frame(1'b1, 1'b0, W*H);
    send_frame(1'b0, 1'b0, W*H);
    idle(3);
    chk("t3_count", win_q.size(), 8);
    if (win_q.size() == 8) check_std_frame("t3b", 4);

    // Reset after pixel 0x21, then a fresh frame without sof.
    clear_log();
    send_frame(1'b1, 1'b0, 2*W + 2);
    drive(1'b1, 1'b1, 1'b0, 8'hee);
    @(negedge clk);
    chk("t4_rst_data", m_matrix_data, '0);
    chk("t4_rst_flags", {m_matrix_valid, m_line_last, m_frame_last}, 3'b000);
    reset = 1'b0; s_pixel_valid = 1'b0;
    send_frame(1'b0, 1'b0, W*H);
    idle(3);
    chk("t4_count", win_q.size(), 4);
    if (win_q.size() == 4) check_std_frame("t4", 0);

    // Sof at old pixel (1,2): next window only at new (2,2), ten pixels later.
    clear_log();
    send_frame(1'b1, 1'b0, 2*W + 1);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, k == 0, DW'(8'hb0 + k));
    idle(1);
    chk("t5_no_early_window", win_q.size(), 0);
    drive(1'b0, 1'b1, 1'b0, 8'hba);
    idle(2);
    chk("t5_count", win_q.size(), 1);
    if (win_q.size() == 1) begin
      chk("t5_e0", win_q[0][0 +: DW], 8'hb0);
      chk("t5_centre", win_q[0][4*DW +: DW], 8'hb5);
      chk("t5_e8", win_q[0][8*DW +: DW], 8'hba);
    end

    // Randomized traffic: gaps, occasional sof and reset (with valid to test priority).
    clear_log();
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
      else if (r < 150) drive(1'b0, 1'b1, $urandom_range(0, 59) == 0, DW'($urandom));
      else drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
